// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the issue scoreboard: unit type codes, register
// file size and the "long" (multi-cycle result) predicate.
package issue_scoreboard_pkg;

    localparam int REG_NUM = 32;

    typedef enum logic [3:0] {
        UT_ALU    = 4'd0,
        UT_BR     = 4'd1,
        UT_DIV    = 4'd2,
        UT_PRIV   = 4'd3,
        UT_MUL    = 4'd4,
        UT_DCACHE = 4'd5
    } unit_type_e;

    // Unit types whose result comes back later through a writeback port.
    function automatic logic is_long_type(input logic [3:0] t);
        return (t == 4'(UT_DIV)) || (t == 4'(UT_PRIV)) ||
               (t == 4'(UT_MUL)) || (t == 4'(UT_DCACHE));
    endfunction

    // A slot occupies a scoreboard entry only if it really writes a
    // non-zero destination through a long-latency unit.
    function automatic logic is_long(input logic regwrite, input logic [4:0] rd,
                                     input logic [3:0] t);
        return regwrite && (rd != 5'd0) && is_long_type(t);
    endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Issue-stage <-> scoreboard bundle.
//   master : issue stage (drives slot fields, issue/writeback strobes)
//   slave  : scoreboard (returns hazards, full, busy state)
// Signals: flush, stall, rj/rk/rd/rdsrc/type/regwrite/if per slot 0/1,
//          wb_valid/wb_rd per writeback port 0/1, haz0/haz1, full,
//          busy_vec[31:0], outstanding[5:0].
interface issue_scoreboard_if;
    logic        flush;
    logic        stall;
    logic [4:0]  rj0, rk0, rd0, rj1, rk1, rd1;
    logic        rdsrc0, rdsrc1;
    logic [3:0]  type0, type1;
    logic        regwrite0, regwrite1;
    logic        if0, if1;
    logic        wb_valid0, wb_valid1;
    logic [4:0]  wb_rd0, wb_rd1;
    logic        haz0, haz1;
    logic        full;
    logic [31:0] busy_vec;
    logic [5:0]  outstanding;

    modport master (
        output flush, stall, rj0, rk0, rd0, rj1, rk1, rd1, rdsrc0, rdsrc1,
               type0, type1, regwrite0, regwrite1, if0, if1,
               wb_valid0, wb_valid1, wb_rd0, wb_rd1,
        input  haz0, haz1, full, busy_vec, outstanding
    );

    modport slave (
        input  flush, stall, rj0, rk0, rd0, rj1, rk1, rd1, rdsrc0, rdsrc1,
               type0, type1, regwrite0, regwrite1, if0, if1,
               wb_valid0, wb_valid1, wb_rd0, wb_rd1,
        output haz0, haz1, full, busy_vec, outstanding
    );
endinterface

// File: rtl/issue_scoreboard_popcount.sv
// sb_popcount: number of set bits in a 32-bit vector.
// Ports: vec[31:0] in, count[5:0] out.
module sb_popcount (
    input  logic [31:0] vec,
    output logic [5:0]  count
);
    always_comb begin
        count = '0;
        for (int i = 0; i < 32; i++) begin
            count = count + 6'(vec[i]);
        end
    end
endmodule

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: tracks destination registers of in-flight long-latency
// instructions for a dual-issue stage and flags RAW / capacity hazards.
// Ports: clk, rstn (synchronous, active-low), sb (issue_scoreboard_if.slave).
// Parameter: OUTS_MAX (1..31) maximum simultaneously busy registers.
// Build option: SCOREBOARD_WB_BYPASS_EN -- registers written back this cycle
// are already seen as free by haz0/haz1/full.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int OUTS_MAX = 8
) (
    input  logic              clk,
    input  logic              rstn,
    issue_scoreboard_if.slave sb
);
    localparam logic [5:0] OUTS_LIM = 6'(OUTS_MAX);

    logic [31:0] busy_q;
    logic [5:0]  outstanding_q;

    logic        long0, long1;
    logic        set_req0, set_req1;
    logic        acc0, acc1, new0;
    logic [31:0] clr_mask, base, busy_nxt, hz_busy;
    logic [5:0]  base_cnt, next_cnt, hz_cnt;
    logic        full_w;

    assign long0    = is_long(sb.regwrite0, sb.rd0, sb.type0);
    assign long1    = is_long(sb.regwrite1, sb.rd1, sb.type1);
    assign set_req0 = !sb.stall && sb.if0 && long0;
    assign set_req1 = !sb.stall && sb.if1 && long1;

    // Writebacks are honoured even while the issue stage is stalled.
    always_comb begin
        clr_mask = '0;
        if (sb.wb_valid0) clr_mask[sb.wb_rd0] = 1'b1;
        if (sb.wb_valid1) clr_mask[sb.wb_rd1] = 1'b1;
        clr_mask[0] = 1'b0;
    end

    assign base = busy_q & ~clr_mask;

    sb_popcount u_base_cnt (.vec(base), .count(base_cnt));

    // Sets are applied after clears so a same-cycle set wins. Slot 0 takes
    // priority for the last free entry; a set to an already-busy register
    // (or slot 1 repeating slot 0's rd) consumes no extra capacity.
    assign acc0 = set_req0 && (base[sb.rd0] || (base_cnt < OUTS_LIM));
    assign new0 = acc0 && !base[sb.rd0];
    assign acc1 = set_req1 && (base[sb.rd1] || (acc0 && (sb.rd1 == sb.rd0)) ||
                               ((base_cnt + 6'(new0)) < OUTS_LIM));

    always_comb begin
        busy_nxt = base;
        if (acc0) busy_nxt[sb.rd0] = 1'b1;
        if (acc1) busy_nxt[sb.rd1] = 1'b1;
    end

    sb_popcount u_next_cnt (.vec(busy_nxt), .count(next_cnt));

    always_ff @(posedge clk) begin
        if (!rstn || sb.flush) begin
            busy_q        <= '0;
            outstanding_q <= '0;
        end else begin
            busy_q        <= busy_nxt;
            outstanding_q <= next_cnt;
        end
    end

`ifdef SCOREBOARD_WB_BYPASS_EN
    assign hz_busy = base;
    assign hz_cnt  = base_cnt;
`else
    assign hz_busy = busy_q;
    assign hz_cnt  = outstanding_q;
`endif

    assign full_w = (hz_cnt == OUTS_LIM);

    // Slot 0 also stalls when it would take the last entry while slot 1
    // needs a different one, so the pair never overruns capacity.
    assign sb.haz0 = hz_busy[sb.rj0] | hz_busy[sb.rk0] | (sb.rdsrc0 & hz_busy[sb.rd0]) |
                     (long0 & full_w) |
                     (long0 & (hz_cnt == OUTS_LIM - 6'd1) & long1 & (sb.rd1 != sb.rd0));
    assign sb.haz1 = hz_busy[sb.rj1] | hz_busy[sb.rk1] | (sb.rdsrc1 & hz_busy[sb.rd1]) |
                     (long1 & full_w);

    assign sb.full        = full_w;
    assign sb.busy_vec    = busy_q;
    assign sb.outstanding = outstanding_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
module tb_issue_scoreboard;
    localparam int OUTS_MAX = 8;
`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn;
    int tests_run = 0;
    int tests_failed = 0;
    bit [31:0] m_busy;

    issue_scoreboard_if sb ();
    issue_scoreboard #(.OUTS_MAX(OUTS_MAX)) dut (.clk(clk), .rstn(rstn), .sb(sb));

    always #5 clk = ~clk;

    function automatic int cnt_bits(bit [31:0] v);
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic bit long_m(bit rw, bit [4:0] rd, bit [3:0] t);
        return rw && rd != 0 && t >= 2 && t <= 5;
    endfunction

    function automatic bit [31:0] eff_busy();
        bit [31:0] e = m_busy;
        if (BYP) begin
            if (sb.wb_valid0) e[sb.wb_rd0] = 1'b0;
            if (sb.wb_valid1) e[sb.wb_rd1] = 1'b0;
        end
        return e;
    endfunction

    function automatic bit exp_full();
        return cnt_bits(eff_busy()) == OUTS_MAX;
    endfunction

    function automatic bit exp_haz0();
        bit [31:0] e = eff_busy();
        bit l0 = long_m(sb.regwrite0, sb.rd0, sb.type0);
        bit l1 = long_m(sb.regwrite1, sb.rd1, sb.type1);
        return e[sb.rj0] || e[sb.rk0] || (sb.rdsrc0 && e[sb.rd0]) ||
               (l0 && cnt_bits(e) == OUTS_MAX) ||
               (l0 && cnt_bits(e) == OUTS_MAX - 1 && l1 && sb.rd0 != sb.rd1);
    endfunction

    function automatic bit exp_haz1();
        bit [31:0] e = eff_busy();
        bit l1 = long_m(sb.regwrite1, sb.rd1, sb.type1);
        return e[sb.rj1] || e[sb.rk1] || (sb.rdsrc1 && e[sb.rd1]) ||
               (l1 && cnt_bits(e) == OUTS_MAX);
    endfunction

    // Next scoreboard contents: clears first, then sets (so set wins),
    // sets beyond capacity dropped in slot order.
    function automatic bit [31:0] model_next();
        bit [31:0] nb = m_busy;
        if (!rstn || sb.flush) return '0;
        if (sb.wb_valid0 && sb.wb_rd0 != 0) nb[sb.wb_rd0] = 1'b0;
        if (sb.wb_valid1 && sb.wb_rd1 != 0) nb[sb.wb_rd1] = 1'b0;
        if (!sb.stall) begin
            if (sb.if0 && long_m(sb.regwrite0, sb.rd0, sb.type0) &&
                (nb[sb.rd0] || cnt_bits(nb) < OUTS_MAX)) nb[sb.rd0] = 1'b1;
            if (sb.if1 && long_m(sb.regwrite1, sb.rd1, sb.type1) &&
                (nb[sb.rd1] || cnt_bits(nb) < OUTS_MAX)) nb[sb.rd1] = 1'b1;
        end
        return nb;
    endfunction

    task automatic tick();
        bit [31:0] nb;
        nb = model_next();
        @(posedge clk);
        m_busy = nb;
        #1;
    endtask

    task automatic idle();
        sb.flush = 0; sb.stall = 0;
        sb.rj0 = 0; sb.rk0 = 0; sb.rd0 = 0; sb.rj1 = 0; sb.rk1 = 0; sb.rd1 = 0;
        sb.rdsrc0 = 0; sb.rdsrc1 = 0; sb.type0 = 0; sb.type1 = 0;
        sb.regwrite0 = 0; sb.regwrite1 = 0; sb.if0 = 0; sb.if1 = 0;
        sb.wb_valid0 = 0; sb.wb_valid1 = 0; sb.wb_rd0 = 0; sb.wb_rd1 = 0;
    endtask

    task automatic do_reset();
        idle(); rstn = 0; tick(); rstn = 1;
    endtask

    task automatic issue0(input bit [4:0] rd, input bit [3:0] t);
        sb.if0 = 1; sb.regwrite0 = 1; sb.rd0 = rd; sb.type0 = t;
    endtask

    task automatic issue1(input bit [4:0] rd, input bit [3:0] t);
        sb.if1 = 1; sb.regwrite1 = 1; sb.rd1 = rd; sb.type1 = t;
    endtask

    task automatic test_reset();
        idle(); rstn = 0; tick(); tick(); rstn = 1;
        tests_run++;
        if (sb.busy_vec !== 32'h0) begin tests_failed++; $display("FAIL reset_busy got %h want 0", sb.busy_vec); end
        tests_run++;
        if (sb.outstanding !== 6'd0) begin tests_failed++; $display("FAIL reset_outs got %0d want 0", sb.outstanding); end
        sb.rj0 = 5; sb.rk1 = 9; #1;
        tests_run++;
        if ({sb.haz0, sb.haz1, sb.full} !== 3'b000) begin tests_failed++; $display("FAIL reset_haz_full got %b want 000", {sb.haz0, sb.haz1, sb.full}); end
    endtask

    task automatic test_issue_wb();
        do_reset();
        issue0(5, 2); tick(); idle();
        tests_run++;
        if (sb.busy_vec[5] !== 1'b1) begin tests_failed++; $display("FAIL issue_busy5 got %b want 1", sb.busy_vec[5]); end
        tests_run++;
        if (sb.outstanding !== 6'd1) begin tests_failed++; $display("FAIL issue_outs got %0d want 1", sb.outstanding); end
        sb.rj0 = 5; #1;
        tests_run++;
        if (sb.haz0 !== 1'b1) begin tests_failed++; $display("FAIL raw_haz0 got %b want 1", sb.haz0); end
        sb.rk1 = 5; sb.wb_valid0 = 1; sb.wb_rd0 = 5; #1;
        tests_run++;
        if (sb.haz0 !== !BYP) begin tests_failed++; $display("FAIL wb_same_cycle_haz0 got %b want %b", sb.haz0, !BYP); end
        tests_run++;
        if (sb.haz1 !== !BYP) begin tests_failed++; $display("FAIL wb_same_cycle_haz1 got %b want %b", sb.haz1, !BYP); end
        tick(); sb.wb_valid0 = 0; #1;
        tests_run++;
        if (sb.busy_vec[5] !== 1'b0 || sb.haz0 !== 1'b0) begin tests_failed++; $display("FAIL wb_after got busy5=%b haz0=%b want 0 0", sb.busy_vec[5], sb.haz0); end
    endtask

    task automatic test_set_clear_same();
        do_reset();
        issue0(7, 4); tick(); idle();
        issue0(7, 5); sb.wb_valid0 = 1; sb.wb_rd0 = 7;
        issue1(9, 3); sb.wb_valid1 = 1; sb.wb_rd1 = 0;
        tick(); idle();
        tests_run++;
        if (sb.busy_vec !== 32'h0000_0280) begin tests_failed++; $display("FAIL set_wins got %h want 00000280", sb.busy_vec); end
        tests_run++;
        if (sb.outstanding !== 6'd2) begin tests_failed++; $display("FAIL set_wins_outs got %0d want 2", sb.outstanding); end
        issue0(11, 2); issue1(11, 4); tick(); idle();
        tests_run++;
        if (sb.outstanding !== 6'd3 || sb.busy_vec[11] !== 1'b1) begin tests_failed++; $display("FAIL dual_same_rd got outs=%0d b11=%b want 3 1", sb.outstanding, sb.busy_vec[11]); end
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            issue0(5'(2*k+1), 4); issue1(5'(2*k+2), 5); tick(); idle();
        end
        issue0(7, 2); tick(); idle();
        issue0(10, 2); issue1(11, 4); #1;
        tests_run++;
        if (sb.haz0 !== 1'b1 || sb.haz1 !== 1'b0) begin tests_failed++; $display("FAIL last_slot_pair got haz0=%b haz1=%b want 1 0", sb.haz0, sb.haz1); end
        sb.rd1 = 10; #1;
        tests_run++;
        if (sb.haz0 !== 1'b0) begin tests_failed++; $display("FAIL last_slot_same_rd got %b want 0", sb.haz0); end
        idle(); issue0(8, 3); tick(); idle();
        tests_run++;
        if (sb.full !== 1'b1 || sb.outstanding !== 6'd8) begin tests_failed++; $display("FAIL full got full=%b outs=%0d want 1 8", sb.full, sb.outstanding); end
        sb.regwrite0 = 1; sb.rd0 = 20; sb.type0 = 2;
        sb.regwrite1 = 1; sb.rd1 = 21; sb.type1 = 0; sb.rj1 = 22; sb.rk1 = 23; #1;
        tests_run++;
        if (sb.haz0 !== 1'b1 || sb.haz1 !== 1'b0) begin tests_failed++; $display("FAIL full_haz got haz0=%b haz1=%b want 1 0", sb.haz0, sb.haz1); end
        sb.rj1 = 3; #1;
        tests_run++;
        if (sb.haz1 !== 1'b1) begin tests_failed++; $display("FAIL full_alu_src got %b want 1", sb.haz1); end
        sb.if0 = 1; tick(); idle();
        tests_run++;
        if (sb.busy_vec[20] !== 1'b0 || sb.outstanding !== 6'd8) begin tests_failed++; $display("FAIL overflow_drop got b20=%b outs=%0d want 0 8", sb.busy_vec[20], sb.outstanding); end
    endtask

    task automatic test_stall();
        do_reset();
        issue0(4, 2); tick(); idle();
        sb.stall = 1; issue0(3, 2); sb.wb_valid1 = 1; sb.wb_rd1 = 4; tick(); idle();
        tests_run++;
        if (sb.busy_vec !== 32'h0 || sb.outstanding !== 6'd0) begin tests_failed++; $display("FAIL stall got busy=%h outs=%0d want 0 0", sb.busy_vec, sb.outstanding); end
    endtask

    task automatic test_flush();
        do_reset();
        issue0(1, 2); issue1(2, 3); tick(); idle();
        issue0(3, 4); issue1(4, 5); tick(); idle();
        sb.flush = 1; issue0(9, 2); sb.wb_valid0 = 1; sb.wb_rd0 = 1; tick(); idle();
        tests_run++;
        if (sb.busy_vec !== 32'h0 || sb.outstanding !== 6'd0) begin tests_failed++; $display("FAIL flush got busy=%h outs=%0d want 0 0", sb.busy_vec, sb.outstanding); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        issue0(6, 2); issue1(12, 4); tick(); idle();
        rstn = 0; issue0(13, 2); tick(); idle(); rstn = 1;
        sb.rj0 = 6; sb.rk1 = 12; #1;
        tests_run++;
        if ({sb.haz0, sb.haz1, sb.full} !== 3'b000 || sb.busy_vec !== 32'h0) begin tests_failed++; $display("FAIL mid_reset got haz=%b%b full=%b busy=%h want 0", sb.haz0, sb.haz1, sb.full, sb.busy_vec); end
        sb.wb_valid0 = 1; sb.wb_rd0 = 6; tick(); idle();
        tests_run++;
        if (sb.busy_vec !== 32'h0 || sb.outstanding !== 6'd0) begin tests_failed++; $display("FAIL stale_wb got busy=%h outs=%0d want 0 0", sb.busy_vec, sb.outstanding); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rstn = ($urandom_range(0, 60) != 0);
            sb.flush = ($urandom_range(0, 40) == 0);
            sb.stall = ($urandom_range(0, 3) == 0);
            sb.rj0 = 5'($urandom_range(0, 11)); sb.rk0 = 5'($urandom_range(0, 11)); sb.rd0 = 5'($urandom_range(0, 11));
            sb.rj1 = 5'($urandom_range(0, 11)); sb.rk1 = 5'($urandom_range(0, 11)); sb.rd1 = 5'($urandom_range(0, 11));
            sb.rdsrc0 = 1'($urandom_range(0, 1)); sb.rdsrc1 = 1'($urandom_range(0, 1));
            sb.type0 = 4'($urandom_range(0, 7)); sb.type1 = 4'($urandom_range(0, 7));
            sb.regwrite0 = ($urandom_range(0, 3) != 0); sb.regwrite1 = ($urandom_range(0, 3) != 0);
            sb.if0 = ($urandom_range(0, 3) != 0); sb.if1 = ($urandom_range(0, 3) != 0);
            sb.wb_valid0 = ($urandom_range(0, 2) == 0); sb.wb_valid1 = ($urandom_range(0, 2) == 0);
            sb.wb_rd0 = 5'($urandom_range(0, 11)); sb.wb_rd1 = 5'($urandom_range(0, 11));
            #1;
            tests_run++;
            if (sb.haz0 !== exp_haz0()) begin tests_failed++; $display("FAIL rand_haz0 cyc %0d got %b want %b", n, sb.haz0, exp_haz0()); end
            tests_run++;
            if (sb.haz1 !== exp_haz1()) begin tests_failed++; $display("FAIL rand_haz1 cyc %0d got %b want %b", n, sb.haz1, exp_haz1()); end
            tests_run++;
            if (sb.full !== exp_full()) begin tests_failed++; $display("FAIL rand_full cyc %0d got %b want %b", n, sb.full, exp_full()); end
            tick();
            tests_run++;
            if (sb.busy_vec !== m_busy) begin tests_failed++; $display("FAIL rand_busy cyc %0d got %h want %h", n, sb.busy_vec, m_busy); end
            tests_run++;
            if (sb.outstanding !== 6'(cnt_bits(m_busy))) begin tests_failed++; $display("FAIL rand_outs cyc %0d got %0d want %0d", n, sb.outstanding, cnt_bits(m_busy)); end
        end
        idle(); rstn = 1;
    endtask

    initial begin
        m_busy = '0;
        rstn = 0;
        idle();
        test_reset();
        test_issue_wb();
        test_set_clear_same();
        test_full();
        test_stall();
        test_flush();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 SHALL have parameter: OUTS_MAX, 8, maximum simultaneously busy destination registers (1..31).
REQ-002 SHALL have port: clk  in  1  single clock, all state on posedge.
REQ-003 SHALL have port: rstn  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port: flush  in  1  pipeline flush.
REQ-005 SHALL have port: stall  in  1  issue stage frozen.
REQ-006 SHALL have ports: rj0,rk0,rd0,rj1,rk1,rd1  in  5 each  register fields of issue slots 0/1.
REQ-007 SHALL have ports: rdsrc0,rdsrc1  in  1 each  slot reads rd as source (control bit 29).
REQ-008 SHALL have ports: type0,type1  in  4 each  unit type code; regwrite0,regwrite1  in  1 each  slot writes rd.
REQ-009 SHALL have ports: if0,if1  in  1 each  slot actually issued this cycle.
REQ-010 SHALL have ports: wb_valid0,wb_valid1  in  1 each, wb_rd0,wb_rd1  in  5 each  multi-cycle result written back.
REQ-011 SHALL have ports: haz0,haz1  out  1 each  slot has RAW hazard on a busy register.
REQ-012 SHALL have ports: full  out  1  busy count == OUTS_MAX; busy_vec  out  32  registered busy bits; outstanding  out  6  registered busy count.

Function
REQ-013 A slot SHALL be "long" when regwrite is 1, rd != 0 and type in {2 div, 3 priv, 4 mul, 5 dcache}.
REQ-014 On posedge with !stall, each slot with if=1 and long SHALL set busy[rd].
REQ-015 On every posedge (stall or not), each wb_valid=1 with wb_rd != 0 SHALL clear busy[wb_rd].
REQ-016 Set and clear of the same register in one cycle: set SHALL win.
REQ-017 Both slots setting same rd SHALL yield a single busy bit, outstanding incremented by one.
REQ-018 busy[0] SHALL be constant 0; wb_rd=0 and rd=0 SHALL be ignored.
REQ-019 outstanding SHALL equal popcount of busy_vec, updated in the same cycle as busy_vec.
REQ-020 haz0 SHALL be busy[rj0] | busy[rk0] | (rdsrc0 & busy[rd0]), combinational from registered busy_vec.
REQ-021 haz1 SHALL use slot-1 fields identically, OR (long slot-1 & full).
REQ-022 haz0 SHALL also assert when slot 0 is long and full, or slot 0 long and outstanding == OUTS_MAX-1 and slot 1 long with different rd.
REQ-023 Sets that would exceed OUTS_MAX SHALL never occur when callers honour haz0/haz1; if violated, extra sets SHALL be dropped and outstanding saturates at OUTS_MAX.
REQ-024 full SHALL be outstanding == OUTS_MAX, combinational from registers.

Reset
REQ-025 rstn=0 at posedge SHALL clear busy_vec and outstanding to 0; haz0, haz1, full therefore 0.
REQ-026 flush=1 at posedge SHALL clear all busy bits and outstanding, overriding same-cycle sets and clears.
REQ-027 Reset mid-operation SHALL discard all pending entries; later wb_valid for them SHALL have no effect.

Configuration
REQ-028 Macro SCOREBOARD_WB_BYPASS_EN defined: a register cleared by wb_valid this cycle SHALL be treated not busy in haz0/haz1 this cycle (and not counted toward full).
REQ-029 Macro undefined: haz0/haz1/full SHALL depend only on registered state; hazard drops one cycle after writeback.

Structure
REQ-030 Shared package SHALL hold type codes (ALU=0, BR=1, DIV=2, PRIV=3, MUL=4, DCACHE=5), REG_NUM=32, and the long-type predicate.
REQ-031 Sub-module sb_popcount (32-bit in, 6-bit out) SHALL compute next outstanding.

Verification
REQ-032 Issue slot0 div rd=5 (if0=1) -> next cycle busy_vec[5]=1, outstanding=1; slot rj=5 -> haz=1.
REQ-033 wb_valid0=1 wb_rd=5 -> same cycle haz=0 with bypass, next cycle without; busy_vec[5]=0 next cycle.
REQ-034 Same cycle issue long rd=7 and wb rd=7 -> busy_vec[7]=1, outstanding unchanged+1 net.
REQ-035 Fill 8 long rds (OUTS_MAX=8) -> full=1, long slot asserts haz; ALU slot no hazard unless source busy.
REQ-036 stall=1 with if0=1 long rd=3 -> no set; wb clear still applies.
REQ-037 flush with 4 busy entries and simultaneous set -> next cycle busy_vec=0, outstanding=0.
